// File: rtl/holy_axi_rr_arbiter_if.sv
// Request/grant and AXI handshake-snoop bundle for holy_axi_rr_arbiter.
// The master modport is the requester/wrapper side and the slave modport is the arbiter.
interface holy_axi_rr_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] owner_idx;
  logic             busy;
  logic             m_arvalid;
  logic             m_arready;
  logic             m_awvalid;
  logic             m_awready;
  logic             m_rvalid;
  logic             m_rready;
  logic             m_rlast;
  logic             m_bvalid;
  logic             m_bready;
  logic             ar_block;
  logic             aw_block;
  logic             wdog_err;

  modport master (
    output req, m_arvalid, m_arready, m_awvalid, m_awready,
           m_rvalid, m_rready, m_rlast, m_bvalid, m_bready,
    input  grant, owner_idx, busy, ar_block, aw_block, wdog_err
  );

  modport slave (
    input  req, m_arvalid, m_arready, m_awvalid, m_awready,
           m_rvalid, m_rready, m_rlast, m_bvalid, m_bready,
    output grant, owner_idx, busy, ar_block, aw_block, wdog_err
  );
endinterface

// File: rtl/holy_axi_rr_arbiter.sv
// Round-robin owner of the single external AXI master port; a grant is held until all owner traffic drains.
// Optional stuck-owner watchdog is built when HOLY_ARB_WATCHDOG_EN is defined.
module holy_axi_rr_arbiter #(
  parameter int N_REQ       = 2,
  parameter int MAX_OUTST   = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  holy_axi_rr_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_busy;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;

  logic [CNT_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_wr_next;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_ptr_after;
  logic             w_any_req;
  logic             w_rd_inc;
  logic             w_rd_dec;
  logic             w_wr_inc;
  logic             w_wr_dec;
  logic             w_owner_req;
  logic             w_done;
  logic             w_wdog_fire;

  assign w_rd_inc    = bus.m_arvalid & bus.m_arready;
  assign w_rd_dec    = bus.m_rvalid & bus.m_rready & bus.m_rlast;
  assign w_wr_inc    = bus.m_awvalid & bus.m_awready;
  assign w_wr_dec    = bus.m_bvalid & bus.m_bready;
  assign w_owner_req = bus.req[r_owner];
  assign w_done      = (w_rd_next == '0) && (w_wr_next == '0);
  assign w_ptr_after = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Lowest offset from the pointer wins, so scan offsets from the far end down.
  always_comb begin
    w_pick    = '0;
    w_cand    = '0;
    w_any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (bus.req[w_cand]) begin
        w_pick    = w_cand;
        w_any_req = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_next = r_rd_cnt;
    if (w_rd_inc && !w_rd_dec && (r_rd_cnt != CNT_W'(MAX_OUTST)))
      w_rd_next = r_rd_cnt + CNT_W'(1);
    else if (w_rd_dec && !w_rd_inc && (r_rd_cnt != '0))
      w_rd_next = r_rd_cnt - CNT_W'(1);
  end

  always_comb begin
    w_wr_next = r_wr_cnt;
    if (w_wr_inc && !w_wr_dec && (r_wr_cnt != CNT_W'(MAX_OUTST)))
      w_wr_next = r_wr_cnt + CNT_W'(1);
    else if (w_wr_dec && !w_wr_inc && (r_wr_cnt != '0))
      w_wr_next = r_wr_cnt - CNT_W'(1);
  end

`ifdef HOLY_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_err;

  assign w_wdog_fire = (r_state != IDLE) && !(w_rd_dec || w_wr_dec) &&
                       (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  // Held at zero while idle so every new grant starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= w_wdog_fire;
      if ((r_state == IDLE) || w_rd_dec || w_wr_dec || w_wdog_fire)
        r_wdog_cnt <= '0;
      else
        r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
    end
  end

  assign bus.wdog_err = r_wdog_err;
`else
  assign w_wdog_fire  = 1'b0;
  // WDOG_CYCLES only matters when the watchdog is built.
  assign bus.wdog_err = (WDOG_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_busy   <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_rd_cnt <= w_rd_next;
      r_wr_cnt <= w_wr_next;
      if (w_wdog_fire) begin
        r_state  <= IDLE;
        r_grant  <= '0;
        r_owner  <= '0;
        r_busy   <= 1'b0;
        r_rr_ptr <= w_ptr_after;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_any_req) begin
              r_state <= GRANTED;
              r_grant <= N_REQ'(1) << w_pick;
              r_owner <= w_pick;
              r_busy  <= 1'b1;
            end
          end
          GRANTED: begin
            if (!w_owner_req) begin
              if (w_done) begin
                r_state  <= IDLE;
                r_grant  <= '0;
                r_owner  <= '0;
                r_busy   <= 1'b0;
                r_rr_ptr <= w_ptr_after;
              end else begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            // The owner's req is deliberately ignored here; only draining ends the grant.
            if (w_done) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_owner  <= '0;
              r_busy   <= 1'b0;
              r_rr_ptr <= w_ptr_after;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.owner_idx = r_owner;
  assign bus.busy      = r_busy;
  assign bus.ar_block  = (r_rd_cnt == CNT_W'(MAX_OUTST));
  assign bus.aw_block  = (r_wr_cnt == CNT_W'(MAX_OUTST));
endmodule

// File: doc/holy_axi_rr_arbiter.md
Name: holy_axi_rr_arbiter

Overview:
- Parametrised N-requester arbiter that owns the core's single external AXI master port. Successor to the fixed two-way instruction/data arbiter.
- Any number of cache or DMA requesters compete for the port. Round-robin fairness is enforced.
- A grant is locked until every AXI transaction the owner issued has completed.
- The block snoops master-side handshakes to track outstanding reads and writes. Channel muxing is driven from `owner_idx` by the surrounding wrapper.

Parameters:
- `N_REQ`, 2, number of requesters (2..8).
- `MAX_OUTST`, 4, maximum outstanding transactions per direction while granted.
- `WDOG_CYCLES`, 1024, watchdog limit (used only with the optional feature).

Ports:
- `clk` in 1 core clock.
- `rst_n` in 1 asynchronous active-low reset.
- `req` in `N_REQ` requester wants the port; held high until its last transaction is issued.
- `grant` out `N_REQ` one-hot ownership.
- `owner_idx` out `$clog2(N_REQ)` index of the current owner; drives the external muxes.
- `busy` out 1 a grant is active.
- `m_arvalid`, `m_arready` in 1 each: AR handshake snoop.
- `m_awvalid`, `m_awready` in 1 each: AW handshake snoop.
- `m_rvalid`, `m_rready`, `m_rlast` in 1 each: R completion snoop.
- `m_bvalid`, `m_bready` in 1 each: B completion snoop.
- `ar_block` out 1 suppresses owner AR issue when read outstanding = `MAX_OUTST`.
- `aw_block` out 1 suppresses owner AW issue when write outstanding = `MAX_OUTST`.
- `wdog_err` out 1 watchdog fired (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset is asynchronous and active-low. While `rst_n`=0:
  - `grant`=0, `owner_idx`=0, `busy`=0, `ar_block`=0, `aw_block`=0, `wdog_err`=0.
  - Round-robin pointer `rr_ptr`=0. Both counters = 0. State = `IDLE`.
- States:
  - `IDLE`: no owner.
  - `GRANTED`: owner holds the port.
  - `DRAIN`: owner has dropped `req`; waiting for outstanding transactions to complete.
- `IDLE`, any `req` set:
  - Pick the first set bit searching `rr_ptr`, `rr_ptr`+1, … mod `N_REQ`.
  - Register `grant`/`owner_idx`; go to `GRANTED`.
  - Latency: `req` at edge k gives `grant` visible after edge k+1.
  - No `req` set: stay in `IDLE`, outputs 0.
- Read counter `rd_cnt`:
  - Increments on `m_arvalid` & `m_arready`.
  - Decrements on `m_rvalid` & `m_rready` & `m_rlast`.
  - Both events in the same cycle: net 0.
- Write counter `wr_cnt`:
  - Increments on `m_awvalid` & `m_awready`.
  - Decrements on `m_bvalid` & `m_bready`.
  - Simultaneous events: net 0.
- Counter limits:
  - Width `$clog2(MAX_OUTST+1)`. Never wraps.
  - Increment at `MAX_OUTST` is impossible because `ar_block`/`aw_block` are asserted combinationally when the count equals `MAX_OUTST`.
  - Decrement at 0 (spurious response) is ignored; the counter saturates at 0.
- `GRANTED`, owner's `req` drops:
  - Both counters 0 (after this cycle's updates): release immediately. Go to `IDLE`, `grant`=0, `rr_ptr`=`owner_idx`+1 mod `N_REQ`.
  - Otherwise: go to `DRAIN` with `grant` held.
- `DRAIN`:
  - Owner re-asserting `req` is ignored; no re-entry to `GRANTED`.
  - When both counters reach 0, release as above.
- `busy`, `grant` and `owner_idx` stay stable for the whole of `GRANTED` and `DRAIN`.
- Non-owner `req` changes have no effect while `busy`.
- Back-to-back handoff: the release cycle passes through `IDLE` for exactly one cycle. A new grant goes out on the following edge. This guarantees a dead cycle on the bus muxes.
- `N_REQ`=1: that requester always wins; the pointer stays 0.

Optional Feature:
- Macro: `HOLY_ARB_WATCHDOG_EN`.
- Defined:
  - A counter clears on every grant and on every completion handshake, and increments each cycle while `busy`.
  - Reaching `WDOG_CYCLES` forces release to `IDLE` and clears both counters.
  - `wdog_err` pulses high for 1 cycle and `rr_ptr` advances past the owner.
- Undefined: no counter is built, `wdog_err` is constant 0, and a stuck owner holds the port indefinitely.

Test Plan:
- Reset mid-`DRAIN` (`rd_cnt`=2, `grant`=0b01), `rst_n` pulsed low asynchronously between edges -> `grant`=0, `busy`=0 immediately, without waiting for `clk`; counters 0 after release.
- `N_REQ`=2, `req`=0b11 held, each owner issues 1 AR then completes with `rlast` and drops `req` for 1 cycle -> grants alternate 0b01, 0b10, 0b01 with one idle cycle between.
- `N_REQ`=4, `rr_ptr`=2, `req`=0b0011 -> `grant`=0b0001 (wrap-around search), `owner_idx`=0.
- Owner issues 4 ARs with `MAX_OUTST`=4 -> `ar_block`=1 after the 4th handshake. Same-cycle AR handshake plus `rlast` completion at count 4 -> count stays 4. `req` dropped -> `DRAIN` until 4 `rlast` completions, then release.
- Owner 1 with AW+B outstanding drops `req`; `req`[0] rises -> `grant` stays 0b10 until `bvalid`&`bready`, then `IDLE` for 1 cycle, then `grant`=0b01.
- `HOLY_ARB_WATCHDOG_EN`, `WDOG_CYCLES`=16, owner never completes its AR -> release and `wdog_err`=1 for exactly 1 cycle, 16 cycles after the last handshake.
